// File: rtl/runner_scan_engine.sv
// rtl/runner_scan_engine.sv - monster-jump game core: field scroll, jump FSM, collision, score, shared row scan
// Optional feature macro: RUNNER_LFSR_EN (LFSR obstacle generator instead of fixed 16-entry pattern).
module runner_scan_engine #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int PANELS     = 4,
    parameter int PLAYER_COL = 2,
    parameter int JUMP_H     = 3,
    parameter int AIR_TICKS  = 2,
    parameter int MIN_GAP    = 3,
    parameter int SCORE_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     scroll_tick,
    input  logic                     scan_en,
    input  logic                     jump,
    input  logic                     start,
    output logic [ROWS-1:0]          row_sel,
    output logic [PANELS*COLS-1:0]   col_data,
    output logic                     game_over,
    output logic [SCORE_W-1:0]       score
);

    localparam int F  = PANELS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int AW = (AIR_TICKS > 1) ? $clog2(AIR_TICKS) : 1;

    if (ROWS < JUMP_H + 3 || PLAYER_COL < 1 || PLAYER_COL >= F ||
        JUMP_H < 1 || AIR_TICKS < 1 || MIN_GAP < 0) begin : g_bad_cfg
        $error("runner_scan_engine: invalid parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} game_t;
    typedef enum logic [1:0] {J_GROUND, J_RISE, J_AIR, J_FALL} jump_t;

    game_t              state, state_n;
    jump_t              js, js_n;
    logic [RW-1:0]      y, y_n;
    logic [AW-1:0]      air_cnt, air_n;
    logic               req, req_n;
    logic               jump_q;
    logic [F-1:0][1:0]  field;
    logic [1:0]         new_h;
    logic [RW-1:0]      r;
    logic [F-1:0]       col_n;
    logic               run_entry;
    logic               coll;
    logic               shift;

    assign run_entry = (state != S_RUN) && start;
    assign coll      = (state == S_RUN) && (RW'(field[PLAYER_COL]) > y);
    assign shift     = (state == S_RUN) && scroll_tick && !coll;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = S_RUN;
            S_RUN:   if (coll)  state_n = S_OVER;
            S_OVER:  if (start) state_n = S_RUN;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        game_over = (state == S_OVER);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            js      <= J_GROUND;
            y       <= '0;
            air_cnt <= '0;
            req     <= 1'b0;
            jump_q  <= 1'b0;
        end else begin
            js      <= js_n;
            y       <= y_n;
            air_cnt <= air_n;
            req     <= req_n;
            jump_q  <= jump;
        end
    end

    // A request is only latched on the ground; the tick that consumes it already lifts the player to y=1.
    always_comb begin
        js_n  = js;
        y_n   = y;
        air_n = air_cnt;
        req_n = req;
        if (run_entry) begin
            js_n  = J_GROUND;
            y_n   = '0;
            air_n = '0;
            req_n = 1'b0;
        end else if (state == S_RUN) begin
            if (js == J_GROUND && jump && !jump_q) req_n = 1'b1;
            if (shift) begin
                case (js)
                    J_GROUND: if (req) begin
                        req_n = 1'b0;
                        y_n   = RW'(1);
                        air_n = '0;
                        js_n  = (JUMP_H == 1) ? J_AIR : J_RISE;
                    end
                    J_RISE: begin
                        y_n = y + RW'(1);
                        if (y + RW'(1) == RW'(JUMP_H)) begin
                            js_n  = J_AIR;
                            air_n = '0;
                        end
                    end
                    J_AIR: begin
                        if (air_cnt == AW'(AIR_TICKS - 1)) js_n = J_FALL;
                        else                               air_n = air_cnt + AW'(1);
                    end
                    default: begin
                        y_n = y - RW'(1);
                        if (y == RW'(1)) js_n = J_GROUND;
                    end
                endcase
            end
        end
    end

`ifdef RUNNER_LFSR_EN
    localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    logic [7:0]    lfsr;
    logic [GW-1:0] gap;

    always_comb begin
        new_h = 2'd0;
        if (lfsr[2:0] == 3'd0 && gap >= GW'(MIN_GAP))
            new_h = 2'(lfsr[4:3] % 2'd3) + 2'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= 8'hA5;
            gap  <= '0;
        end else if (run_entry) begin
            lfsr <= 8'hA5;
            gap  <= '0;
        end else if (shift) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (new_h != 2'd0)              gap <= '0;
            else if (gap < GW'(MIN_GAP))    gap <= gap + GW'(1);
        end
    end
`else
    logic [3:0] idx;

    always_comb begin
        case (idx)
            4'd4:    new_h = 2'd1;
            4'd8:    new_h = 2'd2;
            4'd13:   new_h = 2'd3;
            default: new_h = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           idx <= 4'd0;
        else if (run_entry) idx <= 4'd0;
        else if (shift)     idx <= idx + 4'd1;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            field <= '0;
            score <= '0;
        end else if (run_entry) begin
            field <= '0;
            score <= '0;
        end else if (shift) begin
            field <= {new_h, field[F-1:1]};
            if (field[PLAYER_COL] != 2'd0 && score != {SCORE_W{1'b1}})
                score <= score + SCORE_W'(1);
        end
    end

    always_comb begin
        col_n = '0;
        for (int c = 0; c < F; c++)
            col_n[c] = (RW'(field[c]) > r) |
                       ((c == PLAYER_COL) && (r >= y) && (r <= y + RW'(2)));
    end

    // Blanking keys off the next state so the display goes dark on the same edge game_over rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r        <= '0;
            row_sel  <= '0;
            col_data <= '0;
        end else if (state_n == S_OVER) begin
            r        <= '0;
            row_sel  <= '0;
            col_data <= '0;
        end else begin
            row_sel  <= ROWS'(1) << r;
            col_data <= col_n;
            if (scan_en) r <= (r == RW'(ROWS - 1)) ? '0 : r + RW'(1);
        end
    end

endmodule
